// File: rtl/mult16_seq.sv
// Sequential 16x16 -> 32-bit unsigned shift-add multiplier using a 16-bit carry-lookahead adder.
// Optional early termination once the remaining multiplier bits are all zero: define MULT_EARLY_EXIT_EN.
module mult16_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_next;
  logic [15:0] mcand, mrem;
  logic [32:0] p_reg, p_step, p_next;
  logic [4:0]  cnt;
  logic        accept, finish;

  logic [15:0] hi, gen, prop, sum;
  logic [3:0]  grp_g, grp_p;
  logic [4:0]  grp_c;
  logic        carry, cout;

  assign hi = p_reg[31:16];

  // 4-bit groups: group carries are looked ahead, bits inside a group take the group carry-in.
  always_comb begin
    gen      = hi & mcand;
    prop     = hi ^ mcand;
    grp_g    = '0;
    grp_p    = '0;
    grp_c    = '0;
    grp_c[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      grp_g[k] = gen[4*k+3]
               | (prop[4*k+3] & gen[4*k+2])
               | (prop[4*k+3] & prop[4*k+2] & gen[4*k+1])
               | (prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & gen[4*k]);
      grp_p[k] = &prop[4*k +: 4];
      grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
    end
    carry = 1'b0;
    sum   = '0;
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0) carry = grp_c[i/4];
      sum[i] = prop[i] ^ carry;
      carry  = gen[i] | (prop[i] & carry);
    end
    cout = grp_c[4];
  end

  always_comb begin
    if (p_reg[0]) p_step = {1'b0, cout, sum, p_reg[15:1]};
    else          p_step = {1'b0, p_reg[32:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    p_next     = p_step;
    busy       = (state != IDLE);
    done       = (state == DONE);
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == 5'd15) begin
          finish     = 1'b1;
          state_next = DONE;
        end
`ifdef MULT_EARLY_EXIT_EN
        // Remaining multiplier bits are zero, so the rest of the iterations are pure shifts.
        if (mrem == 16'd0) begin
          p_next     = p_reg >> (5'd16 - cnt);
          finish     = 1'b1;
          state_next = DONE;
        end
`endif
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mrem    <= '0;
      p_reg   <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      mcand <= a;
      mrem  <= b;
      p_reg <= {17'b0, b};
      cnt   <= '0;
    end else if (state == RUN) begin
      p_reg <= p_next;
      mrem  <= mrem >> 1;
      cnt   <= cnt + 5'd1;
      if (finish) product <= p_next[31:0];
    end
  end

endmodule

// File: tb/tb_mult16_seq.sv
// Scoreboard bench for mult16_seq; expected product and start-to-done latency are queued at each accepted start.
module tb_mult16_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic        busy, done;
  logic [31:0] product;

  typedef struct {
    logic [31:0] prod;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_seen = 0;

  mult16_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
    end
  endtask

  function automatic int expLat(input logic [15:0] bv);
`ifdef MULT_EARLY_EXIT_EN
    int k;
    if (bv == 16'd0) return 1;
    k = 0;
    for (int i = 0; i < 16; i++) if (bv[i]) k = i;
    return (k + 2 > 16) ? 16 : k + 2;
`else
    return (bv == 16'd0) ? 16 : 16;
`endif
  endfunction

  // Every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_seen++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("product", product, e.prod);
        checkOutput("latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv);
    exp_t e;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    e.prod = 32'(av) * 32'(bv);
    e.lat  = expLat(bv);
    e.acc  = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic waitDones(input int target);
    int budget = 0;
    while (done_seen < target && budget < 200) begin
      @(negedge clk);
      #1;
      budget++;
    end
    checkOutput("done_count", 32'(done_seen), 32'(target));
  endtask

  task automatic checkIdle(input string tag);
    @(negedge clk);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int target;
    int period;
    logic [15:0] ra, rb;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_product", product, 32'd0);
    rst_n = 1'b1;
    target = 0;

    applyStimulus(16'd3, 16'd5);
    target++; waitDones(target); checkIdle("idle_3x5");

    applyStimulus(16'hFFFF, 16'hFFFF);
    target++; waitDones(target); checkIdle("idle_ffff");

    // start during RUN with new operands must be ignored
    applyStimulus(16'd2, 16'd9);
    a = 16'd7; b = 16'd7; start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    target++; waitDones(target);
    repeat (4) @(negedge clk);
    checkOutput("product_hold", product, 32'h00000012);
    applyStimulus(16'd7, 16'd7);
    target++; waitDones(target); checkIdle("idle_7x7");

    // reset in the middle of a run discards it
    @(negedge clk);
    a = 16'h00AB; b = 16'h8001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_product", product, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    checkIdle("post_rst");
    applyStimulus(16'd4, 16'd4);
    target++; waitDones(target); checkIdle("idle_4x4");

    applyStimulus(16'h1234, 16'h0004);
    target++; waitDones(target);
    applyStimulus(16'hBEEF, 16'h0000);
    target++; waitDones(target);

    for (int i = 0; i < 3; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      applyStimulus(ra, rb);
      target++; waitDones(target);
    end

    // start held high: accepted again on the first IDLE cycle after each DONE
    period = expLat(16'h0100) + 2;
    @(negedge clk);
    a = 16'h0100; b = 16'h0100; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.prod = 32'h00010000;
      e.lat  = expLat(16'h0100);
      e.acc  = cyc + 1 + i * period;
      sb.push_back(e);
    end
    repeat (2 * period + 1) @(negedge clk);
    start = 1'b0;
    target += 3; waitDones(target); checkIdle("idle_b2b");

    repeat (20) @(negedge clk);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    checkOutput("done_total", 32'(done_seen), 32'(target));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
